// File: rtl/ram_ctrl_pkg.sv
// Shared definitions for the RAM port arbiter: FSM encoding, default widths,
// and a small helper used when rotating arbitration priority.
package ram_ctrl_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Priority always moves to the requester that lost (or was absent).
  function automatic logic other_id(input logic id);
    return ~id;
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: chooses the winner for this cycle and reports
// where priority should point once that grant is taken.
module rr_pick2
  import ram_ctrl_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic prio,
  output logic gnt_id,
  output logic gnt_valid,
  output logic next_prio
);

  always_comb begin
    gnt_valid = req0 | req1;
    gnt_id    = 1'b0;
    if (req0 && req1) begin
      gnt_id = prio;
    end else if (req1) begin
      gnt_id = 1'b1;
    end
    next_prio = gnt_valid ? other_id(gnt_id) : prio;
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one asynchronous-read RAM port between two requesters. Each accepted
// request runs IDLE -> ACCESS -> DONE; ack pulses in DONE.
// Handshake: a requester holds req until it sees its one-cycle ack; requests
// are only sampled in IDLE, so a req still high in the ack cycle is not
// re-accepted.
module ram_port_arbiter
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output state_t            fsm_state
);

  state_t              state;
  state_t              next_state;
  logic                prio;
  logic                lat_id;
  logic                lat_we;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;
  logic [DATA_W-1:0]   rdata_q;
  logic                gnt_id;
  logic                gnt_valid;
  logic                next_prio;
  logic                accept;

  rr_pick2 u_pick (
    .req0      (req0),
    .req1      (req1),
    .prio      (prio),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .next_prio (next_prio)
  );

  assign accept = (state == IDLE) && gnt_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (gnt_valid) next_state = ACCESS;
      ACCESS:  next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Winner's request is frozen here so later input changes cannot leak in.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio      <= 1'b0;
      lat_id    <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rdata_q   <= '0;
    end else begin
      if (accept) begin
        prio      <= next_prio;
        lat_id    <= gnt_id;
        lat_we    <= gnt_id ? we1 : we0;
        lat_addr  <= gnt_id ? addr1 : addr0;
        lat_wdata <= gnt_id ? wdata1 : wdata0;
      end
      if ((state == ACCESS) && !lat_we) begin
        rdata_q <= ram_rdata;
      end
    end
  end

  // Outputs decode straight from state, so a reset asserted in ACCESS still
  // lets that cycle's strobe commit, and one asserted in DONE keeps the ack.
  always_comb begin
    ram_we    = (state == ACCESS) && lat_we;
    ack0      = (state == DONE) && !lat_id;
    ack1      = (state == DONE) && lat_id;
    ram_addr  = lat_addr;
    ram_wdata = lat_wdata;
    rdata     = rdata_q;
    fsm_state = state;
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed plus randomized bench for ram_port_arbiter with an external 16x8
// memory and a scoreboard of expected acks.
module tb_ram_port_arbiter;
  import ram_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, we0, req1, we1;
  logic [3:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       ack0, ack1;
  logic [7:0] rdata;
  logic       ram_we;
  logic [3:0] ram_addr;
  logic [7:0] ram_wdata;
  logic [7:0] ram_rdata;
  state_t     fsm_state;

  typedef struct {
    bit         id;
    bit         is_read;
    logic [7:0] data;
    int         start;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] mem [16];
  logic [7:0] ref_mem [16];
  logic [7:0] last_rdata;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  int         we_cnt = 0;
  int         ack_cnt = 0;
  int         prev_ack = -1;
  bit         spacing_on = 1'b0;

  ram_port_arbiter #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req0      (req0),
    .we0       (we0),
    .addr0     (addr0),
    .wdata0    (wdata0),
    .req1      (req1),
    .we1       (we1),
    .addr1     (addr1),
    .wdata1    (wdata1),
    .ack0      (ack0),
    .ack1      (ack1),
    .rdata     (rdata),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .fsm_state (fsm_state)
  );

  // clock / memory
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem[i]     = 8'h00;
      ref_mem[i] = 8'h00;
    end
  end

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    cyc++;
  end
  assign ram_rdata = mem[ram_addr];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: pops one entry per ack
  always @(negedge clk) begin
    if (ram_we) we_cnt++;
    if (ack0 || ack1) begin
      exp_t e;
      ack_cnt++;
      check("ack_onehot", {31'b0, ack0 & ack1}, 32'd0);
      check("ack_expected", {31'b0, exp_q.size() > 0}, 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("ack_id", {31'b0, ack1}, {31'b0, e.id});
        if (e.is_read) begin
          check("read_data", {24'b0, rdata}, {24'b0, e.data});
          last_rdata = e.data;
        end else begin
          check("rdata_hold_on_write", {24'b0, rdata}, {24'b0, last_rdata});
        end
        if (e.start >= 0) check("ack_latency", cyc - e.start, 32'd2);
      end
      if (spacing_on && prev_ack >= 0) check("ack_spacing", cyc - prev_ack, 32'd3);
      prev_ack = cyc;
    end
  end

  // driver tasks
  task automatic push_exp(input bit id, input bit we, input logic [3:0] a,
                          input logic [7:0] d, input int start);
    exp_t e;
    e.id      = id;
    e.is_read = !we;
    e.data    = we ? 8'h00 : ref_mem[a];
    e.start   = start;
    exp_q.push_back(e);
    if (we) ref_mem[a] = d;
  endtask

  task automatic drive(input bit id, input bit r, input bit we, input logic [3:0] a,
                       input logic [7:0] d);
    if (id) begin
      req1 = r; we1 = we; addr1 = a; wdata1 = d;
    end else begin
      req0 = r; we0 = we; addr0 = a; wdata0 = d;
    end
  endtask

  task automatic wait_drain(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      if (exp_q.size() == 0) break;
    end
    #1;
    check("drain_in_time", exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  // One transaction from IDLE; inputs are scrambled after acceptance and req
  // is held across the DONE->IDLE edge before being dropped.
  task automatic xfer(input bit id, input bit we, input logic [3:0] a, input logic [7:0] d);
    push_exp(id, we, a, d, cyc);
    drive(id, 1'b1, we, a, d);
    @(posedge clk);
    #1;
    drive(id, 1'b1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
          8'($urandom_range(0, 255)));
    wait_drain(10);
    drive(id, 1'b0, 1'b0, 4'h0, 8'h00);
  endtask

  initial begin
    int         we_before, ack_before;
    logic [3:0] ra;
    logic [7:0] rd;
    bit         rid;

    rst = 1'b1;
    last_rdata = 8'h00;
    drive(0, 1'b1, 1'b1, 4'd7, 8'h11);
    drive(1, 1'b1, 1'b1, 4'd8, 8'h22);
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {30'b0, fsm_state}, {30'b0, IDLE});
    check("reset_ack0", {31'b0, ack0}, 32'd0);
    check("reset_ack1", {31'b0, ack1}, 32'd0);
    check("reset_rdata", {24'b0, rdata}, 32'd0);
    check("reset_ram_we", {31'b0, ram_we}, 32'd0);
    check("reset_ram_addr", {28'b0, ram_addr}, 32'd0);
    check("reset_ram_wdata", {24'b0, ram_wdata}, 32'd0);

    // both requesters held from reset: grants 0,1,0,1 three cycles apart
    push_exp(0, 1, 4'd7, 8'h11, cyc);
    push_exp(1, 1, 4'd8, 8'h22, -1);
    push_exp(0, 1, 4'd7, 8'h11, -1);
    push_exp(1, 1, 4'd8, 8'h22, -1);
    spacing_on = 1'b1;
    prev_ack = -1;
    rst = 1'b0;
    wait_drain(30);
    drive(0, 1'b0, 1'b0, 4'h0, 8'h00);
    drive(1, 1'b0, 1'b0, 4'h0, 8'h00);

    // requester 1 alone, held for four back-to-back reads
    prev_ack = -1;
    for (int i = 0; i < 4; i++) push_exp(1, 0, 4'd8, 8'h00, (i == 0) ? cyc : -1);
    drive(1, 1'b1, 1'b0, 4'd8, 8'h00);
    wait_drain(30);
    drive(1, 1'b0, 1'b0, 4'h0, 8'h00);
    spacing_on = 1'b0;

    // write then read back through requester 0
    xfer(0, 1, 4'd3, 8'hA5);
    check("hold_ram_addr", {28'b0, ram_addr}, 32'd3);
    check("hold_ram_wdata", {24'b0, ram_wdata}, 32'hA5);
    check("idle_ram_we", {31'b0, ram_we}, 32'd0);
    xfer(0, 0, 4'd3, 8'h00);

    // top address written by 0, read by 1
    xfer(0, 1, 4'd15, 8'h3C);
    xfer(1, 0, 4'd15, 8'h00);
    xfer(1, 0, 4'd7, 8'h00);

    // reset in the ACCESS cycle of a write: write commits, no ack
    drive(0, 1'b1, 1'b1, 4'd5, 8'h77);
    @(posedge clk);
    #1;
    check("access_ram_we", {31'b0, ram_we}, 32'd1);
    check("access_ram_addr", {28'b0, ram_addr}, 32'd5);
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 4'h0, 8'h00);
    ref_mem[5] = 8'h77;
    @(posedge clk);
    #1;
    rst = 1'b0;
    last_rdata = 8'h00;
    check("rst_access_state", {30'b0, fsm_state}, {30'b0, IDLE});
    ack_before = ack_cnt;
    repeat (4) @(posedge clk);
    #1;
    check("rst_access_no_ack", ack_cnt - ack_before, 32'd0);
    xfer(1, 0, 4'd5, 8'h00);

    // reset in the DONE cycle: ack still seen, gone afterwards
    push_exp(0, 0, 4'd3, 8'h00, cyc);
    drive(0, 1'b1, 1'b0, 4'd3, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 4'h0, 8'h00);
    @(posedge clk);
    #1;
    rst = 1'b0;
    last_rdata = 8'h00;
    check("rst_done_drained", exp_q.size(), 32'd0);
    check("rst_done_ack0", {31'b0, ack0}, 32'd0);
    check("rst_done_rdata", {24'b0, rdata}, 32'd0);

    // req held through its ack cycle: one ack, one memory strobe
    we_before  = we_cnt;
    ack_before = ack_cnt;
    xfer(0, 1, 4'd9, 8'h5A);
    repeat (4) @(posedge clk);
    #1;
    check("single_strobe", we_cnt - we_before, 32'd1);
    check("single_ack", ack_cnt - ack_before, 32'd1);

    // randomized write by one requester, read back by the other
    for (int i = 0; i < 6; i++) begin
      rid = 1'($urandom_range(0, 1));
      ra  = 4'($urandom_range(0, 15));
      rd  = 8'($urandom_range(0, 255));
      xfer(rid, 1, ra, rd);
      xfer(~rid, 0, ra, 8'h00);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 4, SHALL set the address width of every address port.
REQ-002 Parameter DATA_W, default 8, SHALL set the data width of every data port.
REQ-003 clk  in  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 rst  in  1  SHALL be a synchronous, active-high reset.
REQ-005 req0 / req1  in  1  SHALL be the access requests from requester 0 / 1; each is held high until its ack.
REQ-006 we0 / we1  in  1  SHALL select write (1) or read (0) for requester 0 / 1.
REQ-007 addr0 / addr1  in  ADDR_W  SHALL be the word address for requester 0 / 1.
REQ-008 wdata0 / wdata1  in  DATA_W  SHALL be the write data for requester 0 / 1.
REQ-009 ack0 / ack1  out  1  SHALL be a one-cycle completion pulse to requester 0 / 1.
REQ-010 rdata  out  DATA_W  SHALL be the registered read data, valid while ack0 or ack1 is high after a read.
REQ-011 ram_we  out  1  SHALL be the memory write strobe, which the memory commits on the rising clk edge.
REQ-012 ram_addr  out  ADDR_W  SHALL be the memory address.
REQ-013 ram_wdata  out  DATA_W  SHALL be the memory write data.
REQ-014 ram_rdata  in  DATA_W  SHALL be the memory's asynchronous read data for ram_addr.

Function
REQ-015 The FSM SHALL have three states: IDLE, ACCESS, DONE. Transitions: IDLE->ACCESS when req0|req1; ACCESS->DONE unconditionally; DONE->IDLE unconditionally.
REQ-016 In IDLE with at least one request, the winner's id, we, addr and wdata SHALL be latched at the clock edge.
REQ-017 Arbitration SHALL be round-robin via a priority bit prio (0 = requester 0 first): a lone requester always wins; when both request, requester prio wins.
REQ-018 After every grant, prio SHALL be set to the id of the requester that was not granted.
REQ-019 In ACCESS, ram_addr/ram_wdata SHALL equal the latched addr/wdata and ram_we SHALL equal the latched we. ram_we SHALL be 0 in every other state.
REQ-020 ram_addr and ram_wdata SHALL hold their latched values outside ACCESS.
REQ-021 At the end of an ACCESS read, rdata SHALL capture ram_rdata. A write SHALL leave rdata unchanged.
REQ-022 In DONE, ack of the latched id SHALL be 1 for exactly one cycle; the other ack SHALL be 0. Latency SHALL be 2 cycles from the accept edge to the ack cycle, with a maximum of one transaction per 3 cycles.
REQ-023 Requests SHALL NOT be sampled in ACCESS or DONE, so a req still high during its ack cycle is not re-accepted.
REQ-024 Requester inputs that change after acceptance SHALL NOT affect the transaction in flight.
REQ-025 The address range SHALL be 0..2^ADDR_W-1 with no wrap logic; any addr is legal.

Reset
REQ-026 On rst, the next state SHALL be IDLE, with ack0 = ack1 = 0, rdata = 0, prio = 0, latched addr/wdata = 0, latched we = 0 and ram_we = 0.
REQ-027 If rst is asserted during ACCESS, a write already strobed in that cycle SHALL commit (the memory is not reset); no ack SHALL follow and the transaction SHALL be dropped.
REQ-028 If rst is asserted during DONE, the ack SHALL still be visible in that cycle and SHALL be 0 afterwards.

Structure
REQ-029 The FSM state encoding (IDLE/ACCESS/DONE) and the default widths SHALL live in a shared package, ram_ctrl_pkg.
REQ-030 Winner selection plus the prio update SHALL be a single sub-module, rr_pick2 (inputs req0, req1, prio; outputs gnt_id, gnt_valid).
REQ-031 The 16x8 memory SHALL be external, and the bench SHALL instantiate it on the ram_* ports.

Verification
REQ-032 Scenario: requester 0 writes addr 3, data 0xA5, then reads addr 3 -> ack0 at +2 cycles for each; rdata = 0xA5 on the read ack.
REQ-033 Scenario: req0 and req1 both high from reset and held continuously -> grants alternate 0,1,0,1, each 3 cycles apart.
REQ-034 Scenario: requester 1 alone requests 4 times back-to-back -> all 4 granted to requester 1; ack0 stays 0.
REQ-035 Scenario: requester 0 writes 0x3C to addr 15, then requester 1 reads addr 15 -> rdata = 0x3C with ack1.
REQ-036 Scenario: rst asserted in the ACCESS cycle of a write of 0x77 to addr 5 -> no ack, FSM in IDLE, and a subsequent read of addr 5 returns 0x77.
REQ-037 Scenario: req0 still high in its ack cycle, then dropped -> exactly one ack0 and exactly one memory access.
